// File: rtl/cpu_bus_capture_if.sv
// rtl/cpu_bus_capture_if.sv - NES CPU bus raw inputs and captured-cycle outputs
interface cpu_bus_capture_if;
    logic        m2_raw;
    logic        rw_raw;
    logic [15:0] addr_raw;
    logic [7:0]  data_raw;
    logic [15:0] cpu_addr_q;
    logic [7:0]  cpu_data_q;
    logic        cpu_rw_q;
    logic        wr_pulse;
    logic        rd_pulse;
    logic        busy;

    modport master (
        output m2_raw, rw_raw, addr_raw, data_raw,
        input  cpu_addr_q, cpu_data_q, cpu_rw_q, wr_pulse, rd_pulse, busy
    );

    modport slave (
        input  m2_raw, rw_raw, addr_raw, data_raw,
        output cpu_addr_q, cpu_data_q, cpu_rw_q, wr_pulse, rd_pulse, busy
    );
endinterface

// File: rtl/cpu_bus_capture.sv
// rtl/cpu_bus_capture.sv - synchronizes the NES CPU bus and strobes each completed M2 cycle
// Optional rejected-cycle counter on glitch_cnt when CPU_GLITCH_COUNT_EN is defined.
module cpu_bus_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cpu_bus_capture_if.slave   bus
`ifdef CPU_GLITCH_COUNT_EN
    ,
    output logic [7:0]         glitch_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, HIGH_WAIT, VALID} state_t;

    localparam logic [3:0] MIN_HIGH_C = 4'(MIN_HIGH);

    state_t                           state_q, state_d;
    logic [3:0]                       hcnt_q, hcnt_d, hcnt_inc;
    logic [SYNC_STAGES-1:0]           m2_sync_q, m2_sync_d;
    logic [SYNC_STAGES-1:0]           rw_sync_q, rw_sync_d;
    logic [SYNC_STAGES-1:0][15:0]     addr_sync_q, addr_sync_d;
    logic [SYNC_STAGES-1:0][7:0]      data_sync_q, data_sync_d;
    logic [SYNC_STAGES:0]             prime_q, prime_d;
    logic                             m2_dly_q, m2_dly_d;
    logic                             rise_q, rise_d;
    logic                             fall_q, fall_d;
    logic [15:0]                      cpu_addr_q, cpu_addr_d;
    logic [7:0]                       cpu_data_q, cpu_data_d;
    logic                             cpu_rw_q, cpu_rw_d;
    logic                             wr_pulse_q, wr_pulse_d;
    logic                             rd_pulse_q, rd_pulse_d;
    logic                             busy_q, busy_d;
`ifdef CPU_GLITCH_COUNT_EN
    logic [7:0]                       glitch_cnt_q, glitch_cnt_d;
`endif

    logic        m2_s;
    logic        rw_s;
    logic [15:0] addr_s;
    logic [7:0]  data_s;

    assign m2_s   = m2_sync_q[SYNC_STAGES-1];
    assign rw_s   = rw_sync_q[SYNC_STAGES-1];
    assign addr_s = addr_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    always_comb begin
        m2_sync_d   = {m2_sync_q[SYNC_STAGES-2:0], bus.m2_raw};
        rw_sync_d   = {rw_sync_q[SYNC_STAGES-2:0], bus.rw_raw};
        addr_sync_d = {addr_sync_q[SYNC_STAGES-2:0], bus.addr_raw};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.data_raw};
        // prime_q tracks which synchronized samples postdate reset; a rise only
        // counts when the preceding low sample was real, not a reset zero.
        prime_d     = {prime_q[SYNC_STAGES-1:0], 1'b1};
        m2_dly_d    = m2_s;
        rise_d      = m2_s & ~m2_dly_q & prime_q[SYNC_STAGES];
        fall_d      = ~m2_s & m2_dly_q;

        hcnt_inc     = (hcnt_q == 4'hF) ? hcnt_q : hcnt_q + 4'd1;
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        cpu_addr_d   = cpu_addr_q;
        cpu_data_d   = cpu_data_q;
        cpu_rw_d     = cpu_rw_q;
        wr_pulse_d   = 1'b0;
        rd_pulse_d   = 1'b0;
`ifdef CPU_GLITCH_COUNT_EN
        glitch_cnt_d = glitch_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (rise_q) begin
                    state_d = HIGH_WAIT;
                    hcnt_d  = 4'd0;
                end
            end
            HIGH_WAIT: begin
                if (fall_q) begin
                    state_d = IDLE;
`ifdef CPU_GLITCH_COUNT_EN
                    if (glitch_cnt_q != 8'hFF) glitch_cnt_d = glitch_cnt_q + 8'd1;
`endif
                end else if (m2_s) begin
                    hcnt_d = hcnt_inc;
                    if (hcnt_inc >= MIN_HIGH_C) state_d = VALID;
                end
            end
            VALID: begin
                if (fall_q) begin
                    state_d    = IDLE;
                    wr_pulse_d = ~cpu_rw_q;
                    rd_pulse_d = cpu_rw_q;
                end else if (m2_s) begin
                    // Only M2-high samples load, so the last pre-fall value is kept.
                    hcnt_d     = hcnt_inc;
                    cpu_addr_d = addr_s;
                    cpu_data_d = data_s;
                    cpu_rw_d   = rw_s;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hcnt_q       <= 4'd0;
            m2_sync_q    <= '0;
            rw_sync_q    <= '0;
            addr_sync_q  <= '0;
            data_sync_q  <= '0;
            prime_q      <= '0;
            m2_dly_q     <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            cpu_addr_q   <= 16'h0000;
            cpu_data_q   <= 8'h00;
            cpu_rw_q     <= 1'b1;
            wr_pulse_q   <= 1'b0;
            rd_pulse_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CPU_GLITCH_COUNT_EN
            glitch_cnt_q <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            m2_sync_q    <= m2_sync_d;
            rw_sync_q    <= rw_sync_d;
            addr_sync_q  <= addr_sync_d;
            data_sync_q  <= data_sync_d;
            prime_q      <= prime_d;
            m2_dly_q     <= m2_dly_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_data_q   <= cpu_data_d;
            cpu_rw_q     <= cpu_rw_d;
            wr_pulse_q   <= wr_pulse_d;
            rd_pulse_q   <= rd_pulse_d;
            busy_q       <= busy_d;
`ifdef CPU_GLITCH_COUNT_EN
            glitch_cnt_q <= glitch_cnt_d;
`endif
        end
    end

    assign bus.cpu_addr_q = cpu_addr_q;
    assign bus.cpu_data_q = cpu_data_q;
    assign bus.cpu_rw_q   = cpu_rw_q;
    assign bus.wr_pulse   = wr_pulse_q;
    assign bus.rd_pulse   = rd_pulse_q;
    assign bus.busy       = busy_q;
`ifdef CPU_GLITCH_COUNT_EN
    assign glitch_cnt     = glitch_cnt_q;
`endif

endmodule

// File: doc/cpu_bus_capture.md
CPU_BUS_CAPTURE -- requirements
Module: cpu_bus_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for all raw NES bus inputs (legal 2..4).
REQ-002 SHALL have parameter MIN_HIGH, default 4, minimum synchronized M2-high clk cycles for a valid bus cycle (legal 1..15).
REQ-003 SHALL have ports: clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-004 SHALL have ports: m2_raw  in  1  NES M2; rw_raw  in  1  NES R/W; addr_raw  in  16  CPU address; data_raw  in  8  CPU data bus.
REQ-005 SHALL have ports: cpu_addr_q  out  16  captured address; cpu_data_q  out  8  captured data; cpu_rw_q  out  1  captured R/W.
REQ-006 SHALL have ports: wr_pulse  out  1  one-cycle write-complete strobe; rd_pulse  out  1  one-cycle read-complete strobe; busy  out  1  M2-high cycle in progress.
REQ-007 SHALL have port glitch_cnt  out  8  rejected-cycle count (present only under REQ-024).

Function
REQ-008 SHALL pass m2_raw, rw_raw, addr_raw, data_raw through SYNC_STAGES flops each; all logic uses only synchronized copies.
REQ-009 SHALL detect rise/fall from synchronized M2 and its one-cycle-delayed copy.
REQ-010 SHALL implement states IDLE, HIGH_WAIT, VALID.
REQ-011 IDLE: on synchronized rise -> HIGH_WAIT, clear high counter, busy=1 next cycle.
REQ-012 HIGH_WAIT: counter increments each cycle M2 high; on reaching MIN_HIGH -> VALID; on fall first -> IDLE, no strobe (glitch).
REQ-013 VALID: cpu_addr_q, cpu_rw_q, cpu_data_q reload every cycle from synchronized inputs; on fall -> IDLE, registers hold values from last cycle before the fall.
REQ-014 On VALID->IDLE, SHALL assert wr_pulse (cpu_rw_q=0) or rd_pulse (cpu_rw_q=1) for exactly one clk, in the cycle after the fall is detected.
REQ-015 Raw M2 fall to strobe latency SHALL be SYNC_STAGES+2 clk, fixed.
REQ-016 wr_pulse and rd_pulse SHALL never be asserted together; at most one strobe per M2 cycle.
REQ-017 Captured registers SHALL be stable while a strobe is high and until next VALID entry.
REQ-018 Rise detected in the same cycle as a strobe SHALL be accepted (IDLE->HIGH_WAIT) without losing the strobe.
REQ-019 busy SHALL be 1 in HIGH_WAIT and VALID, 0 in IDLE.
REQ-020 High counter SHALL be 4 bits and saturate; M2 held high indefinitely stays in VALID, no strobe.

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE, synchronizers to 0, counter 0, cpu_addr_q=0x0000, cpu_data_q=0x00, cpu_rw_q=1, wr_pulse=0, rd_pulse=0, busy=0, glitch_cnt=0.
REQ-022 Reset asserted mid-cycle SHALL drop any pending strobe; after release, an M2 already high SHALL NOT produce a strobe (rise required).
REQ-023 Deassertion is assumed synchronized externally; block SHALL accept first rise on second clk after release.

Configuration
REQ-024 Macro CPU_GLITCH_COUNT_EN: defined -> glitch_cnt increments (saturating at 0xFF) on each HIGH_WAIT->IDLE fall; undefined -> glitch_cnt port, counter and logic absent, all other behaviour identical.

Verification
REQ-025 M2 high 10 clk, rw=0, addr=0x8000, data=0x15 -> one wr_pulse, cpu_addr_q=0x8000, cpu_data_q=0x15, SYNC_STAGES+2 clk after raw fall.
REQ-026 M2 high 10 clk, rw=1, addr=0xC123 -> one rd_pulse, cpu_rw_q=1, no wr_pulse.
REQ-027 M2 high 2 clk (MIN_HIGH=4) -> no strobe, busy pulses, glitch_cnt 0->1 with macro; 300 glitches -> glitch_cnt=0xFF.
REQ-028 Data changes 0x11->0x22 one clk before raw fall -> cpu_data_q=0x22 at strobe.
REQ-029 rst_n low during VALID, released with M2 high -> no strobe until next full low-high-low M2 cycle.
REQ-030 Back-to-back M2 cycles, 1 clk synchronized low gap, writes 0x01 then 0x02 -> two wr_pulses, data 0x01 then 0x02.
